// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array output drain.
// Used by systolic_drain (optional accumulation via SYSTOLIC_DRAIN_ACC_EN).
package systolic_pkg;

    localparam int unsigned DEF_ARRAY_M      = 16;
    localparam int unsigned DEF_PE_OUT_WIDTH = 20;
    localparam int unsigned DEF_ACC_WIDTH    = 32;

    // Widest lane the sign-extend helper can produce.
    localparam int unsigned SEXT_MAX_W = 64;
    localparam int unsigned SEXT_IDX_W = $clog2(SEXT_MAX_W);

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } drain_tag_t;

    // Replicates bit from_w-1 of x into all higher bits; from_w must be 1..SEXT_MAX_W-1.
    function automatic logic [SEXT_MAX_W-1:0] sign_extend(input logic [SEXT_MAX_W-1:0] x,
                                                           input int unsigned from_w);
        logic [SEXT_IDX_W-1:0] msb;
        logic [SEXT_MAX_W-1:0] mask;
        msb  = SEXT_IDX_W'(from_w - 1);
        mask = {SEXT_MAX_W{1'b1}} << from_w;
        return x[msb] ? (x | mask) : (x & ~mask);
    endfunction

endpackage

// File: rtl/systolic_drain_fifo.sv
// Synchronous result-vector FIFO; a push while full is accepted only alongside a pop.
// Reads as zero when empty so the head output is clean after reset.
module systolic_drain_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [AddrW:0]   wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = empty ? '0 : mem_q[rd_q[AddrW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AddrW-1:0]] <= wdata;
    end

endmodule

// File: rtl/systolic_drain.sv
// Deskews skewed systolic array rows into aligned vectors and queues them for the consumer.
// Define SYSTOLIC_DRAIN_ACC_EN to accumulate vectors across K-tiles (acc_first/acc_last).
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int unsigned ARRAY_M      = DEF_ARRAY_M,
    parameter int unsigned PE_OUT_WIDTH = DEF_PE_OUT_WIDTH,
    parameter int unsigned ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ARRAY_M*PE_OUT_WIDTH-1:0] systolic_out,
    input  logic                            row0_valid,
    input  logic                            acc_first,
    input  logic                            acc_last,
    output logic [ARRAY_M*ACC_WIDTH-1:0]    out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            overflow,
    output logic                            busy
);

    localparam int unsigned Stages = ARRAY_M - 1;
    localparam int unsigned VecW   = ARRAY_M * ACC_WIDTH;

    drain_tag_t              tag_in, tag_al;
    drain_tag_t              tag_q [Stages];
    logic [PE_OUT_WIDTH-1:0] lane_al [ARRAY_M];
    logic [VecW-1:0]         ext_vec, push_data;
    logic                    push, pop, fifo_full, fifo_empty, drop;
    logic                    pipe_busy, overflow_q;

    assign tag_in = '{valid: row0_valid, first: acc_first, last: acc_last};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < Stages; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < Stages; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_al = tag_q[Stages-1];

    // Row m lags row 0 by m cycles, so it needs ARRAY_M-1-m stages to line up with the tag.
    for (genvar m = 0; m < ARRAY_M; m++) begin : g_row
        localparam int unsigned Depth = ARRAY_M - 1 - m;
        logic [PE_OUT_WIDTH-1:0] row_in;
        assign row_in = systolic_out[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
        if (Depth == 0) begin : g_thru
            assign lane_al[m] = row_in;
        end else begin : g_dly
            logic [PE_OUT_WIDTH-1:0] pipe_q [Depth];
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= row_in;
                    for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign lane_al[m] = pipe_q[Depth-1];
        end
    end

    always_comb begin
        ext_vec = '0;
        for (int m = 0; m < ARRAY_M; m++) begin
            ext_vec[m*ACC_WIDTH +: ACC_WIDTH] =
                ACC_WIDTH'(sign_extend(SEXT_MAX_W'(lane_al[m]), PE_OUT_WIDTH));
        end
    end

`ifdef SYSTOLIC_DRAIN_ACC_EN
    logic [VecW-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = '0;
        for (int m = 0; m < ARRAY_M; m++) begin
            acc_d[m*ACC_WIDTH +: ACC_WIDTH] = tag_al.first ?
                ext_vec[m*ACC_WIDTH +: ACC_WIDTH] :
                acc_q[m*ACC_WIDTH +: ACC_WIDTH] + ext_vec[m*ACC_WIDTH +: ACC_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (tag_al.valid) begin
            acc_q <= acc_d;
        end
    end

    assign push      = tag_al.valid && tag_al.last;
    assign push_data = acc_d;
`else
    logic unused_flags;
    assign unused_flags = tag_al.first ^ tag_al.last;
    assign push         = tag_al.valid;
    assign push_data    = ext_vec;
`endif

    assign pop  = !fifo_empty && out_ready;
    assign drop = push && fifo_full && !pop;

    systolic_drain_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(VecW)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .wdata  (push_data),
        .pop    (pop),
        .rdata  (out_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < Stages; i++) pipe_busy = pipe_busy | tag_q[i].valid;
    end

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign busy      = pipe_busy || !fifo_empty;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain at ARRAY_M=4, FIFO_DEPTH=2.
// Accumulation expectations follow SYSTOLIC_DRAIN_ACC_EN when defined.
module tb_systolic_drain;

    localparam int unsigned M  = 4;
    localparam int unsigned PW = 20;
    localparam int unsigned AW = 32;
    localparam int unsigned FD = 2;

    typedef logic [M-1:0][PW-1:0] rows_t;
    typedef logic [M-1:0][AW-1:0] lanes_t;
    typedef struct {
        string  name;
        rows_t  rows;
        lanes_t exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [M*PW-1:0] systolic_out;
    logic            row0_valid, acc_first, acc_last;
    logic [M*AW-1:0] out_data;
    logic            out_valid, out_ready, overflow, busy;

    vec_t   tbl [3];
    rows_t  sh [M];
    lanes_t got [$];
    int     checks = 0;
    int     errors = 0;
    rows_t  r_a, r_b, r_c, r5, r7, rm2;

    always #5 clk = ~clk;

    systolic_drain #(
        .ARRAY_M(M),
        .PE_OUT_WIDTH(PW),
        .ACC_WIDTH(AW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .systolic_out(systolic_out),
        .row0_valid  (row0_valid),
        .acc_first   (acc_first),
        .acc_last    (acc_last),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [M*AW-1:0] act, input logic [M*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic lanes_t pick(input int k);
        if (got.size() > k) return got[k];
        return 'x;
    endfunction

    // One clock: row m carries the vector issued m cycles earlier; handshakes are logged.
    task automatic step(input logic v, input rows_t r, input logic f, input logic l);
        for (int k = M - 1; k > 0; k--) sh[k] = sh[k-1];
        sh[0]      = v ? r : '0;
        row0_valid = v;
        acc_first  = f;
        acc_last   = l;
        for (int m = 0; m < M; m++) systolic_out[m*PW +: PW] = sh[m][m];
        if (out_valid && out_ready) got.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < M; k++) sh[k] = '0;
        idle(2);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"single", {20'd13, 20'd12, 20'd11, 20'd10},
                   {32'd13, 32'd12, 32'd11, 32'd10}};
        tbl[1] = '{"sext", {20'd0, 20'hFFFFF, 20'd0, 20'd0},
                   {32'd0, 32'hFFFFFFFF, 32'd0, 32'd0}};
        tbl[2] = '{"mixed", {20'h12345, 20'h00001, 20'h7FFFF, 20'h80000},
                   {32'h00012345, 32'h00000001, 32'h0007FFFF, 32'hFFF80000}};
        r_a = {M{20'd1}};
        r_b = {M{20'd2}};
        r_c = {M{20'd3}};
        r5  = {M{20'd5}};
        r7  = {M{20'd7}};
        rm2 = {M{20'hFFFFE}};

        reset_n      = 1'b0;
        out_ready    = 1'b1;
        row0_valid   = 1'b0;
        acc_first    = 1'b0;
        acc_last     = 1'b0;
        systolic_out = '0;
        @(posedge clk);
        #1;
        do_reset();

        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_busy", busy, 0);

        // Single-pass vectors: visible at t0+4 for exactly one cycle.
        for (int i = 0; i < 3; i++) begin
            got.delete();
            step(1'b1, tbl[i].rows, 1'b1, 1'b1);
            idle(2);
            chk({tbl[i].name, "_no_bypass"}, out_valid, 0);
            chk({tbl[i].name, "_busy_pipe"}, busy, 1);
            idle(1);
            chk({tbl[i].name, "_valid"}, out_valid, 1);
            chk({tbl[i].name, "_data"}, out_data, tbl[i].exp);
            idle(1);
            chk({tbl[i].name, "_one_cycle"}, out_valid, 0);
            chk({tbl[i].name, "_idle_busy"}, busy, 0);
        end

        // Back-to-back K-tile vectors 5, 7, -2 flagged first/none/last.
        got.delete();
        step(1'b1, r5, 1'b1, 1'b0);
        step(1'b1, r7, 1'b0, 1'b0);
        step(1'b1, rm2, 1'b0, 1'b1);
        idle(8);
`ifdef SYSTOLIC_DRAIN_ACC_EN
        chk("acc_count", got.size(), 1);
        chk("acc_sum", pick(0), {M{32'd10}});
`else
        chk("pass_count", got.size(), 3);
        chk("pass_0", pick(0), {M{32'd5}});
        chk("pass_1", pick(1), {M{32'd7}});
        chk("pass_2", pick(2), {M{32'hFFFFFFFE}});
`endif

        // Backpressure: third vector dropped when FIFO holds two.
        got.delete();
        out_ready = 1'b0;
        step(1'b1, r_a, 1'b1, 1'b1);
        step(1'b1, r_b, 1'b1, 1'b1);
        step(1'b1, r_c, 1'b1, 1'b1);
        idle(2);
        chk("bp_ovf_not_yet", overflow, 0);
        chk("bp_head_a", out_data, {M{32'd1}});
        idle(1);
        chk("bp_ovf_set", overflow, 1);
        idle(3);
        chk("bp_held_valid", out_valid, 1);
        chk("bp_held_data", out_data, {M{32'd1}});
        out_ready = 1'b1;
        idle(4);
        chk("bp_pop_count", got.size(), 2);
        chk("bp_pop_0", pick(0), {M{32'd1}});
        chk("bp_pop_1", pick(1), {M{32'd2}});
        chk("bp_ovf_sticky", overflow, 1);
        chk("bp_drained", out_valid, 0);

        // Reset two cycles after row0_valid discards the vector and clears overflow.
        step(1'b1, r_a, 1'b1, 1'b1);
        idle(1);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        got.delete();
        idle(6);
        chk("rst_no_output", got.size(), 0);
        chk("rst_ovf_stays", overflow, 0);

        // Push into a full FIFO in the same cycle as a pop is accepted.
        got.delete();
        out_ready = 1'b0;
        step(1'b1, r_a, 1'b1, 1'b1);
        step(1'b1, r_b, 1'b1, 1'b1);
        step(1'b1, r_c, 1'b1, 1'b1);
        idle(2);
        out_ready = 1'b1;
        idle(6);
        chk("full_pop_count", got.size(), 3);
        chk("full_pop_0", pick(0), {M{32'd1}});
        chk("full_pop_1", pick(1), {M{32'd2}});
        chk("full_pop_2", pick(2), {M{32'd3}});
        chk("full_pop_ovf", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
